// File: rtl/spi_flash_rd.sv
// Issues a flash READ (opcode, 24-bit address, N data bytes, deselect) as a series
// of Wishbone transfers toward an SPI master, handing each received byte to a consumer.
module spi_flash_rd #(
  parameter logic [7:0] RD_OPCODE = 8'h03,
  parameter logic [7:0] SS_IDLE   = 8'hFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [23:0] cmd_addr_i,
  input  logic [7:0]  cmd_len_i,
  input  logic [2:0]  cmd_ss_i,
  output logic [7:0]  dat_o,
  output logic        dat_valid_o,
  input  logic        dat_ready_i,
  output logic        done_o,
  output logic [15:0] m_dat_o,
  output logic        m_we_o,
  output logic [1:0]  m_sel_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic [7:0]  m_dat_i,
  input  logic        m_ack_i
);

  typedef enum logic [3:0] {IDLE, SEL, A2, A1, A0, RD, HOLD, DESEL, GAP} state_t;

  state_t      state_q, next_q;
  logic [23:0] addr_q;
  logic [7:0]  cnt_q;
  logic        ready_q, stb_q, we_q, done_q, dval_q;
  logic [1:0]  sel_q;
  logic [15:0] mdat_q;
  logic [7:0]  dat_q;
  logic [7:0]  sel_byte_d;

  assign sel_byte_d = SS_IDLE & ~(8'd1 << cmd_ss_i);

  // next_q remembers where GAP leads, so every transfer is loaded from GAP or IDLE
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      next_q  <= IDLE;
      addr_q  <= 24'd0;
      cnt_q   <= 8'd0;
      ready_q <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 2'b00;
      mdat_q  <= 16'd0;
      dat_q   <= 8'd0;
      dval_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && cmd_valid_i) begin
            ready_q <= 1'b0;
            addr_q  <= cmd_addr_i;
            cnt_q   <= cmd_len_i;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            sel_q   <= 2'b11;
            mdat_q  <= {sel_byte_d, RD_OPCODE};
            state_q <= SEL;
          end
        end
        SEL, A2, A1, A0, RD, DESEL: begin
          if (stb_q && m_ack_i) begin
            stb_q   <= 1'b0;
            state_q <= GAP;
            case (state_q)
              SEL:   next_q <= A2;
              A2:    next_q <= A1;
              A1:    next_q <= A0;
              A0:    next_q <= RD;
              RD: begin
                dat_q   <= m_dat_i;
                dval_q  <= 1'b1;
                state_q <= HOLD;
              end
              DESEL: begin
                done_q <= 1'b1;
                next_q <= IDLE;
              end
              default: next_q <= IDLE;
            endcase
          end
        end
        HOLD: begin
          if (dat_ready_i) begin
            dval_q  <= 1'b0;
            state_q <= GAP;
            if (cnt_q == 8'd0) begin
              next_q <= DESEL;
            end else begin
              cnt_q  <= cnt_q - 8'd1;
              next_q <= RD;
            end
          end
        end
        GAP: begin
          state_q <= next_q;
          case (next_q)
            A2: begin
              stb_q  <= 1'b1;
              we_q   <= 1'b1;
              sel_q  <= 2'b01;
              mdat_q <= {8'h00, addr_q[23:16]};
            end
            A1: begin
              stb_q  <= 1'b1;
              we_q   <= 1'b1;
              sel_q  <= 2'b01;
              mdat_q <= {8'h00, addr_q[15:8]};
            end
            A0: begin
              stb_q  <= 1'b1;
              we_q   <= 1'b1;
              sel_q  <= 2'b01;
              mdat_q <= {8'h00, addr_q[7:0]};
            end
            RD: begin
              stb_q  <= 1'b1;
              we_q   <= 1'b0;
              sel_q  <= 2'b01;
              mdat_q <= 16'h00FF;
            end
            DESEL: begin
              stb_q  <= 1'b1;
              we_q   <= 1'b1;
              sel_q  <= 2'b10;
              mdat_q <= {SS_IDLE, 8'hFF};
            end
            default: ready_q <= 1'b1;
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign m_stb_o     = stb_q;
  assign m_cyc_o     = stb_q;
  assign m_we_o      = we_q;
  assign m_sel_o     = sel_q;
  assign m_dat_o     = mdat_q;
  assign dat_o       = dat_q;
  assign dat_valid_o = dval_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_spi_flash_rd.sv
// Randomized bench for spi_flash_rd: a behavioural Wishbone slave and byte consumer
// compare every transfer and every delivered byte against a per-request transaction list.
module tb_spi_flash_rd;

  logic        clock = 1'b0;
  logic        rstN;
  logic        cmdValid;
  logic        cmdReady;
  logic [23:0] cmdAddr;
  logic [7:0]  cmdLen;
  logic [2:0]  cmdSs;
  logic [7:0]  datO;
  logic        datValid;
  logic        datReady;
  logic        doneO;
  logic [15:0] mDatO;
  logic        mWe;
  logic [1:0]  mSel;
  logic        mStb;
  logic        mCyc;
  logic [7:0]  mDatI;
  logic        mAck;

  always #5 clock = ~clock;

  spi_flash_rd dut (
    .wb_clk_i    (clock),
    .wb_rst_n_i  (rstN),
    .cmd_valid_i (cmdValid),
    .cmd_ready_o (cmdReady),
    .cmd_addr_i  (cmdAddr),
    .cmd_len_i   (cmdLen),
    .cmd_ss_i    (cmdSs),
    .dat_o       (datO),
    .dat_valid_o (datValid),
    .dat_ready_i (datReady),
    .done_o      (doneO),
    .m_dat_o     (mDatO),
    .m_we_o      (mWe),
    .m_sel_o     (mSel),
    .m_stb_o     (mStb),
    .m_cyc_o     (mCyc),
    .m_dat_i     (mDatI),
    .m_ack_i     (mAck)
  );

  int totalChecks = 0;
  int badChecks   = 0;

  logic [31:0] expQ[$];
  logic [7:0]  dataQ[$];
  logic [7:0]  rdQ[$];

  int readyMode = 0;
  int ackLimit  = 1000000;
  int ackCount  = 0;
  int doneCount = 0;
  int waitCnt   = 0;
  int holdCnt   = 0;
  bit inXfer    = 1'b0;
  bit ackPrev   = 1'b0;
  bit deselPrev = 1'b0;
  bit validPrev = 1'b0;
  logic [18:0] snap;
  logic [7:0]  heldVal;
  logic [7:0]  rb;
  logic [31:0] ew;
  logic [15:0] obsDat;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    totalChecks++;
    if (obs !== want) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  // Expected bus transactions of one request: {we, sel, data} in the low 19 bits
  function automatic void buildExp(input logic [23:0] addr, input logic [7:0] len, input logic [2:0] ss);
    logic [7:0] selByte;
    selByte     = 8'hFF;
    selByte[ss] = 1'b0;
    expQ.push_back({13'd0, 1'b1, 2'b11, selByte, 8'h03});
    for (int i = 2; i >= 0; i--) expQ.push_back({13'd0, 1'b1, 2'b01, 8'h00, addr[i*8 +: 8]});
    for (int i = 0; i <= int'(len); i++) expQ.push_back({13'd0, 1'b0, 2'b01, 16'h00FF});
    expQ.push_back({13'd0, 1'b1, 2'b10, 16'hFFFF});
  endfunction

  // Slave and consumer, both acting on the falling edge
  always @(negedge clock) begin
    if (!rstN) begin
      mAck      = 1'b0;
      datReady  = 1'b0;
      inXfer    = 1'b0;
      ackPrev   = 1'b0;
      deselPrev = 1'b0;
      validPrev = 1'b0;
    end else begin
      if (ackPrev) begin
        checkOutput("gap_after_ack", 32'(mStb), 32'd0);
        if (deselPrev) checkOutput("done_after_desel", 32'(doneO), 32'd1);
      end
      if (doneO) doneCount++;
      ackPrev   = 1'b0;
      deselPrev = 1'b0;
      mAck      = 1'b0;
      if (mStb) begin
        if (!inXfer) begin
          inXfer  = 1'b1;
          snap    = {mWe, mSel, mDatO};
          waitCnt = $urandom_range(0, 3);
          if (!mWe) checkOutput("read_while_valid", 32'(datValid), 32'd0);
        end
        if (waitCnt == 0 && ackCount < ackLimit) begin
          mAck    = 1'b1;
          ackPrev = 1'b1;
          inXfer  = 1'b0;
          ackCount++;
          checkOutput("stable", 32'({mWe, mSel, mDatO}), 32'(snap));
          checkOutput("cyc", 32'(mCyc), 32'd1);
          obsDat = (mWe && mSel == 2'b01) ? {8'h00, mDatO[7:0]} : mDatO;
          if (expQ.size() == 0) begin
            checkOutput("extra_xfer", 32'(expQ.size()), 32'd1);
          end else begin
            ew = expQ.pop_front();
            checkOutput("xfer", {13'd0, mWe, mSel, obsDat}, ew);
          end
          if (!mWe) begin
            if (rdQ.size() > 0) rb = rdQ.pop_front();
            else rb = 8'($urandom);
            mDatI = rb;
            dataQ.push_back(rb);
          end else begin
            mDatI = 8'($urandom);
          end
          if (mSel == 2'b10) deselPrev = 1'b1;
        end else if (waitCnt > 0) begin
          waitCnt--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mAck  = 1'b1;
        mDatI = 8'($urandom);
      end

      if (datValid) begin
        if (!validPrev) begin
          if (dataQ.size() > 0) checkOutput("read_byte", 32'(datO), 32'(dataQ[0]));
          else checkOutput("unexpected_valid", 32'(datValid), 32'd0);
          heldVal = datO;
          holdCnt = 0;
        end else begin
          checkOutput("held_byte", 32'(datO), 32'(heldVal));
        end
        holdCnt++;
      end
      case (readyMode)
        0:       datReady = 1'b1;
        1:       datReady = datValid && (holdCnt > 10);
        default: datReady = 1'($urandom_range(0, 1));
      endcase
      if (datValid && datReady) begin
        if (dataQ.size() > 0) rb = dataQ.pop_front();
        validPrev = 1'b0;
      end else begin
        validPrev = datValid;
      end
    end
  end

  task automatic waitReady();
    int n;
    n = 0;
    while (cmdReady !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("cmd_ready", 32'(cmdReady), 32'd1);
  endtask

  task automatic applyStimulus(input logic [23:0] addr, input logic [7:0] len, input logic [2:0] ss, input bit poke);
    int n;
    int pokes;
    buildExp(addr, len, ss);
    doneCount = 0;
    pokes     = 0;
    waitReady();
    cmdAddr  = addr;
    cmdLen   = len;
    cmdSs    = ss;
    cmdValid = 1'b1;
    @(negedge clock);
    cmdValid = 1'b0;
    n = 0;
    while (doneCount == 0 && n < 20000) begin
      @(negedge clock);
      n++;
      if (poke) begin
        if (mStb && !mWe && pokes < 3) begin
          cmdValid = 1'b1;
          cmdAddr  = 24'($urandom);
          checkOutput("ready_busy", 32'(cmdReady), 32'd0);
          pokes++;
        end else begin
          cmdValid = 1'b0;
        end
      end
    end
    cmdValid = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("done_count", 32'(doneCount), 32'd1);
    checkOutput("xfer_left", 32'(expQ.size()), 32'd0);
    checkOutput("data_left", 32'(dataQ.size()), 32'd0);
  endtask

  initial begin
    int n;
    rstN     = 1'b0;
    cmdValid = 1'b0;
    cmdAddr  = 24'd0;
    cmdLen   = 8'd0;
    cmdSs    = 3'd0;
    mAck     = 1'b0;
    mDatI    = 8'd0;
    datReady = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("rst_ready", 32'(cmdReady), 32'd0);
    checkOutput("rst_stb", 32'(mStb), 32'd0);
    checkOutput("rst_cyc", 32'(mCyc), 32'd0);
    checkOutput("rst_we", 32'(mWe), 32'd0);
    checkOutput("rst_sel", 32'(mSel), 32'd0);
    checkOutput("rst_mdat", 32'(mDatO), 32'd0);
    checkOutput("rst_dat", 32'(datO), 32'd0);
    checkOutput("rst_valid", 32'(datValid), 32'd0);
    checkOutput("rst_done", 32'(doneO), 32'd0);
    rstN = 1'b1;
    @(negedge clock);
    checkOutput("ready_after_rst", 32'(cmdReady), 32'd1);
    checkOutput("idle_stb", 32'(mStb), 32'd0);

    $display("[TB] single byte read");
    readyMode = 0;
    rdQ.push_back(8'hA5);
    applyStimulus(24'h123456, 8'd0, 3'd2, 1'b0);

    $display("[TB] four bytes with slow consumer");
    readyMode = 1;
    rdQ = '{8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(24'h00ABCD, 8'd3, 3'd0, 1'b0);

    $display("[TB] 256 byte read");
    readyMode = 2;
    applyStimulus(24'($urandom), 8'd255, 3'($urandom_range(0, 7)), 1'b0);

    $display("[TB] command poked while busy");
    readyMode = 1;
    applyStimulus(24'hFFFFFF, 8'd2, 3'd7, 1'b1);

    $display("[TB] random requests");
    for (int k = 0; k < 6; k++) begin
      readyMode = $urandom_range(0, 2);
      applyStimulus(24'($urandom), 8'($urandom_range(0, 20)), 3'($urandom_range(0, 7)), 1'b0);
    end

    $display("[TB] reset during A1");
    readyMode = 0;
    buildExp(24'hABCDEF, 8'd5, 3'd1);
    doneCount = 0;
    ackLimit  = ackCount + 2;
    waitReady();
    cmdAddr  = 24'hABCDEF;
    cmdLen   = 8'd5;
    cmdSs    = 3'd1;
    cmdValid = 1'b1;
    @(negedge clock);
    cmdValid = 1'b0;
    n = 0;
    while (!(mStb && ackCount == ackLimit) && n < 100) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    checkOutput("a1_strobe", 32'(mStb), 32'd1);
    checkOutput("a1_addr", 32'(mDatO[7:0]), 32'h0000_00CD);
    rstN = 1'b0;
    @(negedge clock);
    checkOutput("rst_mid_stb", 32'(mStb), 32'd0);
    checkOutput("rst_mid_cyc", 32'(mCyc), 32'd0);
    checkOutput("rst_mid_done", 32'(doneO), 32'd0);
    checkOutput("rst_mid_ready", 32'(cmdReady), 32'd0);
    expQ.delete();
    dataQ.delete();
    rdQ.delete();
    ackLimit = 1000000;
    rstN = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("no_done_after_rst", 32'(doneCount), 32'd0);
    readyMode = 2;
    applyStimulus(24'h5A5A5A, 8'd4, 3'd5, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
